// File: rtl/key_coalescing_matcher.sv
// key_coalescing_matcher: FIFO of keyed entries where an arriving key that is already resident merges into that entry.
module key_coalescing_matcher #(
  parameter int DEPTH  = 8,
  parameter int KWIDTH = 16,
  parameter int DWIDTH = 16,
  parameter int CWIDTH = 3,
  parameter int MODE   = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_enque_en,
  output logic                       in_valid,
  input  logic [KWIDTH-1:0]          in_key,
  input  logic [DWIDTH-1:0]          in_data,
  input  logic                       out_deque_en,
  output logic                       out_valid,
  output logic [KWIDTH-1:0]          out_key,
  output logic [DWIDTH-1:0]          out_data,
  output logic [CWIDTH-1:0]          out_count,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       merge_pulse
);
  localparam int aw = $clog2(DEPTH);
  localparam logic [aw:0] full = (aw+1)'(DEPTH);
  logic [KWIDTH-1:0] key_q [DEPTH];
  logic [DWIDTH-1:0] data_q [DEPTH];
  logic [CWIDTH-1:0] cnt_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [aw-1:0]     head, tail, hit_idx;
  logic [aw:0]       occ;
  logic [DEPTH-1:0]  hit;
  logic              hit_any, accept, pop, alloc;
  logic [DWIDTH:0]   sum;
  logic [DWIDTH-1:0] merged, old_data;
  logic [CWIDTH-1:0] cnt_inc;
  assign occupancy = occ;
  assign in_valid  = occ != full;
  assign out_valid = vld_q[head];
  assign out_key   = out_valid ? key_q[head] : '0;
  assign out_data  = out_valid ? data_q[head] : '0;
  assign out_count = out_valid ? cnt_q[head] : '0;
  assign accept    = in_enque_en && in_valid;
  assign pop       = out_deque_en && out_valid;
  assign hit_any   = |hit;
  assign alloc     = accept && !hit_any;
  // an entry leaving this cycle cannot absorb the item, so it allocates fresh instead
  always_comb begin
    hit = '0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = vld_q[i] && key_q[i] == in_key && !(pop && head == aw'(i));
      if (hit[i]) hit_idx = aw'(i);
    end
  end
  always_comb begin
    old_data = data_q[hit_idx];
    sum      = {1'b0, old_data} + {1'b0, in_data};
    merged   = MODE == 1 ? (sum[DWIDTH] ? '1 : sum[DWIDTH-1:0]) :
               MODE == 2 ? (old_data | in_data) : in_data;
    cnt_inc  = &cnt_q[hit_idx] ? cnt_q[hit_idx] : cnt_q[hit_idx] + 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        key_q[i]  <= '0;
        data_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      vld_q       <= '0;
      head        <= '0;
      tail        <= '0;
      occ         <= '0;
      merge_pulse <= 1'b0;
    end else begin
      merge_pulse <= accept && hit_any;
      if (pop) begin
        vld_q[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      if (accept && hit_any) begin
        data_q[hit_idx] <= merged;
        cnt_q[hit_idx]  <= cnt_inc;
      end
      if (alloc) begin
        key_q[tail]  <= in_key;
        data_q[tail] <= in_data;
        cnt_q[tail]  <= CWIDTH'(1);
        vld_q[tail]  <= 1'b1;
        tail         <= tail + 1'b1;
      end
      occ <= occ + {{aw{1'b0}}, alloc} - {{aw{1'b0}}, pop};
    end
  end
endmodule

// File: tb/tb_key_coalescing_matcher.sv
// tb_key_coalescing_matcher: three DUTs (one per merge mode) on shared stimulus, scoreboarded against a queue model.
module tb_key_coalescing_matcher;
  typedef struct packed {
    logic [15:0]      key;
    logic [2:0]       cnt;
    logic [2:0][15:0] data;
  } rec_t;
  logic        clk = 0, rst = 1;
  logic        in_enque_en = 0, out_deque_en = 0;
  logic [15:0] in_key = 0, in_data = 0;
  logic        o_in_valid [3];
  logic        o_valid [3];
  logic [15:0] o_key [3];
  logic [15:0] o_data [3];
  logic [2:0]  o_count [3];
  logic [3:0]  o_occ [3];
  logic        o_mp [3];
  rec_t        model [$];
  rec_t        expq [$];
  rec_t        mon_e;
  logic        exp_mp = 0;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : u
    key_coalescing_matcher #(.MODE(g)) dut (
      .clk(clk), .rst(rst), .in_enque_en(in_enque_en), .in_valid(o_in_valid[g]),
      .in_key(in_key), .in_data(in_data), .out_deque_en(out_deque_en),
      .out_valid(o_valid[g]), .out_key(o_key[g]), .out_data(o_data[g]),
      .out_count(o_count[g]), .occupancy(o_occ[g]), .merge_pulse(o_mp[g])
    );
  end
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic logic [15:0] mrg(input int m, input logic [15:0] o, input logic [15:0] i);
    int s;
    s = int'(o) + int'(i);
    if (m == 1) return s > 65535 ? 16'hFFFF : 16'(s);
    if (m == 2) return o | i;
    return i;
  endfunction
  task automatic chk_state();
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("occ%0d", g), int'(o_occ[g]), model.size());
      chk($sformatf("in_valid%0d", g), int'(o_in_valid[g]), int'(model.size() != 8));
      chk($sformatf("merge_pulse%0d", g), int'(o_mp[g]), int'(exp_mp));
      chk($sformatf("out_valid%0d", g), int'(o_valid[g]), int'(model.size() > 0));
      if (model.size() > 0) begin
        chk($sformatf("head_key%0d", g), int'(o_key[g]), int'(model[0].key));
        chk($sformatf("head_data%0d", g), int'(o_data[g]), int'(model[0].data[g]));
        chk($sformatf("head_count%0d", g), int'(o_count[g]), int'(model[0].cnt));
      end
    end
  endtask
  task automatic step(input logic en, input logic [15:0] k, input logic [15:0] d, input logic deq);
    logic pop, acc;
    int hi;
    rec_t r;
    in_enque_en = en; in_key = k; in_data = d; out_deque_en = deq;
    pop = deq && model.size() > 0;
    acc = en && model.size() < 8;
    if (pop) expq.push_back(model[0]);
    hi = -1;
    foreach (model[i]) if (model[i].key == k && !(pop && i == 0)) hi = i;
    exp_mp = acc && hi >= 0;
    if (exp_mp) begin
      r = model[hi];
      for (int g = 0; g < 3; g++) r.data[g] = mrg(g, r.data[g], d);
      r.cnt = r.cnt == 3'd7 ? 3'd7 : r.cnt + 3'd1;
      model[hi] = r;
    end
    if (pop) void'(model.pop_front());
    if (acc && hi < 0) begin
      r.key = k; r.cnt = 3'd1; r.data = {d, d, d};
      model.push_back(r);
    end
    @(posedge clk); #1;
    in_enque_en = 0; out_deque_en = 0;
    chk_state();
  endtask
  task automatic drain();
    repeat (9) step(0, 16'h0, 16'h0, 1);
  endtask
  always @(negedge clk) begin
    if (!rst && out_deque_en && (o_valid[0] || o_valid[1] || o_valid[2])) begin
      if (expq.size() == 0) begin
        checks++; errors++;
        $display("FAIL pop_unexpected got key=%0h expected no record", o_key[0]);
      end else begin
        mon_e = expq.pop_front();
        for (int g = 0; g < 3; g++) begin
          chk($sformatf("pop_valid%0d", g), int'(o_valid[g]), 1);
          chk($sformatf("pop_key%0d", g), int'(o_key[g]), int'(mon_e.key));
          chk($sformatf("pop_data%0d", g), int'(o_data[g]), int'(mon_e.data[g]));
          chk($sformatf("pop_count%0d", g), int'(o_count[g]), int'(mon_e.cnt));
        end
      end
    end
  end
  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    chk_state();
    step(1, 16'h0011, 16'h0005, 0);
    step(1, 16'h0022, 16'h0007, 0);
    step(0, 16'h0, 16'h0, 1);
    step(0, 16'h0, 16'h0, 1);
    step(1, 16'h00AA, 16'h0003, 0);
    step(1, 16'h00AA, 16'hFFFE, 0);
    step(1, 16'h00AA, 16'h0004, 0);
    drain();
    repeat (10) step(1, 16'h0001, 16'(1 << $urandom_range(0, 15)), 0);
    drain();
    for (int i = 0; i < 8; i++) step(1, 16'(i), 16'(16'h100 + i), 0);
    step(1, 16'h0003, 16'h0055, 0);
    step(1, 16'h0003, 16'h0055, 1);
    drain();
    step(1, 16'h0005, 16'h0001, 0);
    step(1, 16'h0005, 16'h0009, 1);
    drain();
    for (int i = 0; i < 4; i++) step(1, 16'(16'h40 + i), 16'(16'h200 + i), 0);
    #3 rst = 1;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst_out_valid%0d", g), int'(o_valid[g]), 0);
      chk($sformatf("rst_occ%0d", g), int'(o_occ[g]), 0);
      chk($sformatf("rst_key%0d", g), int'(o_key[g]), 0);
      chk($sformatf("rst_data%0d", g), int'(o_data[g]), 0);
      chk($sformatf("rst_count%0d", g), int'(o_count[g]), 0);
      chk($sformatf("rst_mp%0d", g), int'(o_mp[g]), 0);
    end
    model.delete();
    expq.delete();
    exp_mp = 0;
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    chk_state();
    step(1, 16'h0042, 16'h0033, 0);
    drain();
    repeat (400)
      step($urandom_range(0, 9) < 6, 16'($urandom_range(0, 11)), 16'($urandom), $urandom_range(0, 9) < 4);
    drain();
    chk("scoreboard_empty", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
